stream_mux4_rr: RTL and testbench

//  4-to-1 stream merger: the gathering counterpart of the 1-to-4 demultiplexer.

---
 rtl/stream_mux4_rr_pkg.sv | 17 +
 rtl/stream_mux4_rr_arbiter.sv | 26 ++
 rtl/stream_mux4_rr.sv | 98 +++++++++
 tb/tb_stream_mux4_rr.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux4_rr_pkg.sv
// rtl/stream_mux4_rr_pkg.sv - shared types and constants for the 4-to-1 round-robin stream merger
package stream_mux4_rr_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Channel after idx in round-robin order; 3 wraps to 0 through the 2-bit width.
   function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] idx);
      return idx + SEL_W'(1);
   endfunction

endpackage

// File: rtl/stream_mux4_rr_arbiter.sv
// rtl/stream_mux4_rr_arbiter.sv - combinational 4-way round-robin pick starting at ptr
module rr_arbiter4
   import stream_mux4_rr_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_any
);

   logic [SEL_W-1:0] cand;

   // Walk from the farthest offset down so the requester nearest to ptr wins last.
   always_comb begin
      gnt_any = |req;
      gnt_idx = ptr;
      cand    = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/stream_mux4_rr.sv
// rtl/stream_mux4_rr.sv - four valid/ready sources merged round-robin into one registered stream
module stream_mux4_rr
   import stream_mux4_rr_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter bit LOCK_PKT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        s_valid,
   output logic [NUM_CH-1:0]        s_ready,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   input  logic [NUM_CH-1:0]        s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_last,
   output logic [SEL_W-1:0]         m_sel
);

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] arb_idx;
   logic             arb_any;
   logic             out_free;
   logic             capture;
   logic             end_grant;

   rr_arbiter4 u_arb (
      .req     (s_valid),
      .ptr     (ptr),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign out_free  = !m_valid || m_ready;
   assign capture   = (state == ST_LOCK) && s_valid[grant] && out_free;
   // Without packet locking every accepted beat releases the grant.
   assign end_grant = capture && (s_last[grant] || !LOCK_PKT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (arb_any)   state_nxt = ST_LOCK;
         ST_LOCK: if (end_grant) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = '0;
      if (state == ST_LOCK) begin
         s_ready[grant] = out_free;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant <= '0;
         ptr   <= '0;
      end else begin
         if (state == ST_IDLE && arb_any) begin
            grant <= arb_idx;
         end
         if (end_grant) begin
            ptr <= next_ch(grant);
         end
      end
   end

   // A capture in the same cycle as a drain replaces the old beat with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_sel   <= '0;
      end else if (capture) begin
         m_valid <= 1'b1;
         m_data  <= s_data[int'(grant)*DATA_W +: DATA_W];
         m_last  <= s_last[grant];
         m_sel   <= grant;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux4_rr.sv
// tb/tb_stream_mux4_rr.sv - self-checking bench for stream_mux4_rr, packet-locked and per-beat variants
module tb_stream_mux4_rr;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [1:0] sel;
      logic [7:0] d;
      logic       l;
      int         cyc;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  sv     [2];
   logic [31:0] sd     [2];
   logic [3:0]  sl     [2];
   logic        mr     [2];
   logic [3:0]  sready [2];
   logic        mv_d   [2];
   logic [7:0]  md_d   [2];
   logic        ml_d   [2];
   logic [1:0]  ms_d   [2];

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    cur    = 0;
   beat_t srcq [4][$];
   out_t  olog [$];

   int         e_own [2];
   int         e_ptr [2];
   logic       e_v   [2];
   logic [7:0] e_d   [2];
   logic       e_l   [2];
   logic [1:0] e_s   [2];
   logic       e_ok  [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_mux4_rr #(.DATA_W(8), .LOCK_PKT(1'b1)) u_dut_lock (
      .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sready[0]), .s_data(sd[0]),
      .s_last(sl[0]), .m_valid(mv_d[0]), .m_ready(mr[0]), .m_data(md_d[0]),
      .m_last(ml_d[0]), .m_sel(ms_d[0])
   );

   stream_mux4_rr #(.DATA_W(8), .LOCK_PKT(1'b0)) u_dut_beat (
      .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sready[1]), .s_data(sd[1]),
      .s_last(sl[1]), .m_valid(mv_d[1]), .m_ready(mr[1]), .m_data(md_d[1]),
      .m_last(ml_d[1]), .m_sel(ms_d[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [7:0] d, input logic l);
      srcq[ch].push_back('{d, l});
   endtask

   task automatic wait_log(input int n, input string name);
      int t = 0;
      while (olog.size() < n && t < 200) begin
         @(negedge clk); #2;
         t++;
      end
      chk(name, olog.size(), n);
   endtask

   task automatic chk_log(input string name, input int idx, input logic [1:0] sel,
                          input logic [7:0] d, input logic l);
      if (idx < olog.size()) begin
         chk({name, " sel"},  olog[idx].sel, sel);
         chk({name, " data"}, olog[idx].d,   d);
         chk({name, " last"}, olog[idx].l,   l);
      end else begin
         chk({name, " present"}, olog.size(), idx + 1);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      for (int k = 0; k < 2; k++) begin
         sv[k] = 4'b0;
         mr[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      olog.delete();
   endtask

   // Sources: present the head of each queue, pop it once the handshake has happened.
   initial begin
      logic [3:0] acc;
      forever begin
         @(negedge clk); #1;
         for (int i = 0; i < 4; i++) acc[i] = !rst && sv[cur][i] && (sready[cur][i] === 1'b1);
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
               sv[cur][i]         = 1'b1;
               sd[cur][i*8 +: 8]  = srcq[i][0].d;
               sl[cur][i]         = srcq[i][0].l;
            end else begin
               sv[cur][i] = 1'b0;
            end
         end
      end
   end

   // Reference: one owner (or none), a rotating start point, and a one-deep output slot.
   always @(negedge clk) begin
      logic [3:0] esr;
      int         nx;
      for (int k = 0; k < 2; k++) begin
         if (e_ok[k]) begin
            esr = 4'b0;
            if (e_own[k] >= 0 && (!e_v[k] || mr[k])) esr[e_own[k]] = 1'b1;
            chk($sformatf("dut%0d s_ready", k), sready[k], esr);
            chk($sformatf("dut%0d m_valid", k), mv_d[k], e_v[k]);
            chk($sformatf("dut%0d m_data",  k), md_d[k], e_d[k]);
            chk($sformatf("dut%0d m_last",  k), ml_d[k], e_l[k]);
            chk($sformatf("dut%0d m_sel",   k), ms_d[k], e_s[k]);
         end
         if (rst) begin
            e_own[k] = -1; e_ptr[k] = 0; e_v[k] = 1'b0;
            e_d[k] = 8'h0; e_l[k] = 1'b0; e_s[k] = 2'd0; e_ok[k] = 1'b1;
         end else if (e_own[k] < 0) begin
            if (e_v[k] && mr[k]) e_v[k] = 1'b0;
            if (sv[k] != 4'b0) begin
               nx = 0;
               for (int j = 3; j >= 0; j--) if (sv[k][(e_ptr[k] + j) % 4]) nx = (e_ptr[k] + j) % 4;
               e_own[k] = nx;
            end
         end else if (sv[k][e_own[k]] && (!e_v[k] || mr[k])) begin
            e_v[k] = 1'b1;
            e_d[k] = sd[k][e_own[k]*8 +: 8];
            e_l[k] = sl[k][e_own[k]];
            e_s[k] = 2'(e_own[k]);
            if (e_l[k] || k == 1) begin
               e_ptr[k] = (e_own[k] + 1) % 4;
               e_own[k] = -1;
            end
         end else if (e_v[k] && mr[k]) begin
            e_v[k] = 1'b0;
         end
      end
      if (mv_d[cur] === 1'b1 && mr[cur] === 1'b1)
         olog.push_back('{ms_d[cur], md_d[cur], ml_d[cur], cyc});
   end

   initial begin
      int p;
      for (int k = 0; k < 2; k++) begin
         sv[k] = 4'b0; sd[k] = 32'h0; sl[k] = 4'b0; mr[k] = 1'b1; e_ok[k] = 1'b0;
         e_own[k] = -1; e_ptr[k] = 0; e_v[k] = 1'b0; e_d[k] = 8'h0; e_l[k] = 1'b0; e_s[k] = 2'd0;
      end
      for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);

      // All sources request during reset; nothing may leave, ch0 wins on release.
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("t1 reset m_valid", mv_d[0], 1'b0);
      chk("t1 reset s_ready", sready[0], 4'b0000);
      chk("t1 reset m_data",  md_d[0], 8'h00);
      @(posedge clk); #2;
      rst = 1'b0;
      wait_log(4, "t1 count");
      chk_log("t1 b0", 0, 2'd0, 8'hA0, 1'b1);
      chk_log("t1 b3", 3, 2'd3, 8'hA3, 1'b1);

      // Single 3-beat packet on ch2: first beat two cycles after it is presented.
      do_reset();
      @(negedge clk);
      p = cyc;
      push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
      wait_log(3, "t2 count");
      chk_log("t2 a1", 0, 2'd2, 8'hA1, 1'b0);
      chk_log("t2 a2", 1, 2'd2, 8'hA2, 1'b0);
      chk_log("t2 a3", 2, 2'd2, 8'hA3, 1'b1);
      if (olog.size() >= 3) begin
         chk("t2 a1 latency", olog[0].cyc - p, 3);
         chk("t2 a3 latency", olog[2].cyc - p, 5);
      end

      // All four at once, then ch0 again: strict rotation.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      push(0, 8'h20, 1'b1);
      wait_log(5, "t3 count");
      chk_log("t3 b0", 0, 2'd0, 8'h10, 1'b1);
      chk_log("t3 b1", 1, 2'd1, 8'h11, 1'b1);
      chk_log("t3 b2", 2, 2'd2, 8'h12, 1'b1);
      chk_log("t3 b3", 3, 2'd3, 8'h13, 1'b1);
      chk_log("t3 b4", 4, 2'd0, 8'h20, 1'b1);

      // Backpressure mid-packet holds the output and stalls the source.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 4; i++) push(1, 8'h41 + 8'(i), i == 3);
      wait_log(1, "t4 first");
      @(posedge clk); #2;
      mr[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #2;
         chk("t4 hold m_valid", mv_d[0], 1'b1);
         chk("t4 hold m_data",  md_d[0], 8'h42);
         chk("t4 hold m_sel",   ms_d[0], 2'd1);
         chk("t4 hold m_last",  ml_d[0], 1'b0);
         chk("t4 hold s_ready", sready[0], 4'b0000);
      end
      @(posedge clk); #2;
      mr[0] = 1'b1;
      wait_log(4, "t4 count");
      for (int i = 0; i < 4; i++) chk_log($sformatf("t4 b%0d", i), i, 2'd1, 8'h41 + 8'(i), i == 3);
      repeat (3) @(negedge clk);
      #2;
      chk("t4 no duplicate", olog.size(), 4);

      // Per-beat arbitration interleaves two 2-beat packets.
      do_reset();
      cur = 1;
      @(negedge clk);
      push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1);
      push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b1);
      wait_log(4, "t5 count");
      chk_log("t5 b0", 0, 2'd0, 8'h50, 1'b0);
      chk_log("t5 b1", 1, 2'd1, 8'h60, 1'b0);
      chk_log("t5 b2", 2, 2'd0, 8'h51, 1'b1);
      chk_log("t5 b3", 3, 2'd1, 8'h61, 1'b1);

      // Reset while ch3's second beat is on the output; pointer returns to 0.
      do_reset();
      cur = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) push(3, 8'h71 + 8'(i), i == 3);
      wait_log(1, "t6 first");
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      sv[0] = 4'b0;
      @(negedge clk); #2;
      chk("t6 beat2 on output", md_d[0], 8'h72);
      @(negedge clk); #2;
      chk("t6 reset m_valid", mv_d[0], 1'b0);
      chk("t6 reset s_ready", sready[0], 4'b0000);
      @(posedge clk); #2;
      rst = 1'b0;
      olog.delete();
      @(negedge clk);
      push(1, 8'h81, 1'b1);
      push(3, 8'h83, 1'b1);
      wait_log(2, "t6 count");
      chk_log("t6 b0", 0, 2'd1, 8'h81, 1'b1);
      chk_log("t6 b1", 1, 2'd3, 8'h83, 1'b1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
